ysyx_22040088_lsu: RTL and testbench

Multi-cycle load/store unit for the RV64 core. Consumes the memory-control fields produced by the instruction decoder (`mem_ena`, `mem_wen`, one-hot `mem_mask`, `sel_memdata`) plus the ALU-computed address and the store data. It issues one aligned 64-bit transaction on the data-bus request/response channels and returns the extracted, extended load result to the writeback stage. It sits between EXU and WBU, with valid/ready handshakes on both sides.

---
 rtl/ysyx_22040088_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_22040088_lsu.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_lsu.sv
// ysyx_22040088_lsu: multi-cycle load/store unit between EXU and WBU.
//
// Accepts one memory-control bundle per transaction from EXU (in_valid/in_ready),
// issues a single aligned 64-bit request on the data bus (bus_req_*), waits for
// the response (bus_resp_*), then presents the extracted and extended load result
// to WBU (out_valid/out_ready). Pass-through and faulting operations skip the bus
// and go straight to the result state.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      EXU handshake
//   mem_ena, mem_wen         access enable, store (1) / load (0)
//   mem_mask                 one-hot size: 0001=8B, 0010=4B, 0100=2B, 1000=1B
//   sel_memdata              bit1 selects zero-extension of load data
//   addr, wdata              byte address, right-justified store data
//   out_valid / out_ready    WBU handshake
//   out_rdata, out_err       extended load data, misalign / bad-mask flag
//   bus_req_valid/ready      bus request handshake
//   bus_addr, bus_wen        aligned address, write request
//   bus_wdata, bus_wstrb     lane-shifted store data, byte strobes
//   bus_resp_valid/ready     bus response handshake
//   bus_rdata                aligned 64-bit read data
module ysyx_22040088_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_ena,
    input  logic        mem_wen,
    input  logic [3:0]  mem_mask,
    input  logic [1:0]  sel_memdata,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [63:0] bus_addr,
    output logic        bus_wen,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    output logic        bus_resp_ready,
    input  logic [63:0] bus_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operation context captured at accept time.
    logic        wen_q, wen_d;
    logic [3:0]  mask_q, mask_d;
    logic        zext_q, zext_d;
    logic [2:0]  off_q, off_d;

    // Registered outputs.
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_rdata_q, out_rdata_d;
    logic        out_err_q, out_err_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic [63:0] bus_addr_q, bus_addr_d;
    logic        bus_wen_q, bus_wen_d;
    logic [63:0] bus_wdata_q, bus_wdata_d;
    logic [7:0]  bus_wstrb_q, bus_wstrb_d;
    logic        bus_resp_ready_q, bus_resp_ready_d;

    // Request-side decode of the incoming bundle.
    logic        mask_ok;
    logic [2:0]  size_m1;
    logic [7:0]  strb;
    logic        misalign;
    logic        issue;

    always_comb begin
        mask_ok = 1'b1;
        size_m1 = 3'd0;
        strb    = 8'h00;
        case (mem_mask)
            4'b0001: begin size_m1 = 3'd7; strb = 8'hFF; end
            4'b0010: begin size_m1 = 3'd3; strb = 8'h0F << addr[2:0]; end
            4'b0100: begin size_m1 = 3'd1; strb = 8'h03 << addr[2:0]; end
            4'b1000: begin size_m1 = 3'd0; strb = 8'h01 << addr[2:0]; end
            default: mask_ok = 1'b0;
        endcase
    end

    assign misalign = (addr[2:0] & size_m1) != 3'd0;
    assign issue    = mem_ena & mask_ok & ~misalign;

    // Response-side extraction: move the addressed lane down, then extend.
    logic [63:0] rsh;
    logic [63:0] load_data;

    assign rsh = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = 64'd0;
        case (mask_q)
            4'b0001: load_data = rsh;
            4'b0010: load_data = zext_q ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
            4'b0100: load_data = zext_q ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
            4'b1000: load_data = zext_q ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}}, rsh[7:0]};
            default: load_data = 64'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        mask_d      = mask_q;
        zext_d      = zext_q;
        off_d       = off_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        bus_addr_d  = bus_addr_q;
        bus_wen_d   = bus_wen_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    wen_d       = mem_wen;
                    mask_d      = mem_mask;
                    zext_d      = sel_memdata[1];
                    off_d       = addr[2:0];
                    bus_addr_d  = {addr[63:3], 3'b000};
                    // Write qualifiers only go high for an access that is really issued.
                    bus_wen_d   = issue & mem_wen;
                    bus_wdata_d = wdata << {addr[2:0], 3'b000};
                    bus_wstrb_d = (issue & mem_wen) ? strb : 8'h00;
                    out_rdata_d = 64'd0;
                    out_err_d   = mem_ena & ~issue;
                    state_d     = issue ? StReq : StDone;
                end
            end
            StReq: begin
                if (bus_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus_resp_valid) begin
                    out_rdata_d = wen_q ? 64'd0 : load_data;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs are decodes of the next state, registered below.
        in_ready_d       = (state_d == StIdle);
        bus_req_valid_d  = (state_d == StReq);
        bus_resp_ready_d = (state_d == StResp);
        out_valid_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            wen_q            <= 1'b0;
            mask_q           <= 4'd0;
            zext_q           <= 1'b0;
            off_q            <= 3'd0;
            in_ready_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_rdata_q      <= 64'd0;
            out_err_q        <= 1'b0;
            bus_req_valid_q  <= 1'b0;
            bus_addr_q       <= 64'd0;
            bus_wen_q        <= 1'b0;
            bus_wdata_q      <= 64'd0;
            bus_wstrb_q      <= 8'd0;
            bus_resp_ready_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wen_q            <= wen_d;
            mask_q           <= mask_d;
            zext_q           <= zext_d;
            off_q            <= off_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            out_rdata_q      <= out_rdata_d;
            out_err_q        <= out_err_d;
            bus_req_valid_q  <= bus_req_valid_d;
            bus_addr_q       <= bus_addr_d;
            bus_wen_q        <= bus_wen_d;
            bus_wdata_q      <= bus_wdata_d;
            bus_wstrb_q      <= bus_wstrb_d;
            bus_resp_ready_q <= bus_resp_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_rdata      = out_rdata_q;
    assign out_err        = out_err_q;
    assign bus_req_valid  = bus_req_valid_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wen        = bus_wen_q;
    assign bus_wdata      = bus_wdata_q;
    assign bus_wstrb      = bus_wstrb_q;
    assign bus_resp_ready = bus_resp_ready_q;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Directed self-checking bench for ysyx_22040088_lsu.
module tb_ysyx_22040088_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mem_ena;
    logic        mem_wen;
    logic [3:0]  mem_mask;
    logic [1:0]  sel_memdata;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_addr;
    logic        bus_wen;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [63:0] bus_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations returned by run_access.
    logic [63:0] r_addr;
    logic        r_wen;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [63:0] r_rdata;
    logic        r_err;
    int          r_lat;
    logic        r_req_seen;
    logic        r_in_ready;
    logic        r_timeout;

    ysyx_22040088_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_ena        (mem_ena),
        .mem_wen        (mem_wen),
        .mem_mask       (mem_mask),
        .sel_memdata    (sel_memdata),
        .addr           (addr),
        .wdata          (wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_wen        (bus_wen),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_ready (bus_resp_ready),
        .bus_rdata      (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Concatenation of every DUT output, for the all-zero reset checks.
    logic [205:0] all_out;
    assign all_out = {in_ready, out_valid, out_rdata, out_err, bus_req_valid, bus_addr,
                      bus_wen, bus_wdata, bus_wstrb, bus_resp_ready};

    // Drives one operation with a zero-wait bus and zero-wait WBU, returning what it saw.
    task automatic run_access(input logic ena, input logic wen, input logic [3:0] mask,
                              input logic [1:0] sel, input logic [63:0] a,
                              input logic [63:0] wd, input logic [63:0] rd);
        int n;
        r_addr = '0; r_wen = 1'b0; r_wdata = '0; r_wstrb = '0;
        r_req_seen = 1'b0; r_timeout = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; mem_ena = ena; mem_wen = wen; mem_mask = mask;
        sel_memdata = sel; addr = a; wdata = wd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            if (bus_req_valid) begin
                r_req_seen = 1'b1;
                r_addr = bus_addr; r_wen = bus_wen; r_wdata = bus_wdata; r_wstrb = bus_wstrb;
                bus_req_ready = 1'b1;
            end
            if (bus_resp_ready) begin
                bus_resp_valid = 1'b1;
                bus_rdata      = rd;
            end
            @(posedge clk); #1;
            n++;
        end
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        r_lat     = n;
        r_timeout = !out_valid;
        r_rdata   = out_rdata;
        r_err     = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        r_in_ready = in_ready;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_in_ready_early: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
        end
    endtask

    task automatic test_loads();
        // lb, sign-extended byte 3
        run_access(1'b1, 1'b0, 4'b1000, 2'b01, 64'h8000_0003, 64'h0, 64'h1122_3344_8566_7788);
        tests_run++;
        if (r_timeout !== 1'b0 || r_lat != 2) begin
            tests_failed++; $display("FAIL lb_latency: got %0d (timeout %b) want 2", r_lat, r_timeout);
        end
        tests_run++;
        if (r_addr !== 64'h8000_0000 || r_wstrb !== 8'h00 || r_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL lb_bus: got addr %h strb %h wen %b want 80000000 00 0", r_addr, r_wstrb, r_wen);
        end
        tests_run++;
        if (r_rdata !== 64'hFFFF_FFFF_FFFF_FF85 || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL lb_data: got %h err %b want ffffffffffffff85 0", r_rdata, r_err);
        end
        tests_run++;
        if (r_in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL lb_in_ready: got %b want 1", r_in_ready);
        end
        // lhu, zero-extended half at offset 6
        run_access(1'b1, 1'b0, 4'b0100, 2'b10, 64'h8000_0006, 64'h0, 64'hABCD_0000_0000_0000);
        tests_run++;
        if (r_rdata !== 64'h0000_0000_0000_ABCD || r_err !== 1'b0) begin
            tests_failed++; $display("FAIL lhu_data: got %h err %b want abcd 0", r_rdata, r_err);
        end
        // lw, sign-extended word at offset 0
        run_access(1'b1, 1'b0, 4'b0010, 2'b00, 64'h8000_0000, 64'h0, 64'h1234_5678_8000_0001);
        tests_run++;
        if (r_rdata !== 64'hFFFF_FFFF_8000_0001) begin
            tests_failed++; $display("FAIL lw_data: got %h want ffffffff80000001", r_rdata);
        end
        // lwu, zero-extended word at offset 4
        run_access(1'b1, 1'b0, 4'b0010, 2'b10, 64'h8000_0104, 64'h0, 64'h9876_5432_0000_1111);
        tests_run++;
        if (r_rdata !== 64'h0000_0000_9876_5432) begin
            tests_failed++; $display("FAIL lwu_data: got %h want 98765432", r_rdata);
        end
        // ld, full dword untouched
        run_access(1'b1, 1'b0, 4'b0001, 2'b00, 64'h8000_0208, 64'h0, 64'hF0E1_D2C3_B4A5_9687);
        tests_run++;
        if (r_rdata !== 64'hF0E1_D2C3_B4A5_9687 || r_addr !== 64'h8000_0208) begin
            tests_failed++; $display("FAIL ld_data: got %h addr %h want f0e1d2c3b4a59687 80000208", r_rdata, r_addr);
        end
    endtask

    task automatic test_stores();
        run_access(1'b1, 1'b1, 4'b0010, 2'b00, 64'h8000_0004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
        tests_run++;
        if (r_wstrb !== 8'hF0 || r_wdata !== 64'hDEAD_BEEF_0000_0000 || r_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL sw_bus: got strb %h wdata %h wen %b want f0 deadbeef00000000 1", r_wstrb, r_wdata, r_wen);
        end
        tests_run++;
        if (r_rdata !== 64'h0 || r_err !== 1'b0 || r_addr !== 64'h8000_0000) begin
            tests_failed++; $display("FAIL sw_result: got %h err %b addr %h want 0 0 80000000", r_rdata, r_err, r_addr);
        end
        run_access(1'b1, 1'b1, 4'b1000, 2'b00, 64'h8000_0005, 64'h0000_00AB, 64'h0);
        tests_run++;
        if (r_wstrb !== 8'h20 || r_wdata !== 64'h0000_AB00_0000_0000) begin
            tests_failed++; $display("FAIL sb_bus: got strb %h wdata %h want 20 0000ab0000000000", r_wstrb, r_wdata);
        end
        run_access(1'b1, 1'b1, 4'b0100, 2'b00, 64'h8000_0002, 64'h0000_BEEF, 64'h0);
        tests_run++;
        if (r_wstrb !== 8'h0C || r_wdata !== 64'h0000_0000_BEEF_0000) begin
            tests_failed++; $display("FAIL sh_bus: got strb %h wdata %h want 0c beef0000", r_wstrb, r_wdata);
        end
        run_access(1'b1, 1'b1, 4'b0001, 2'b00, 64'h8000_0010, 64'h0102_0304_0506_0708, 64'h0);
        tests_run++;
        if (r_wstrb !== 8'hFF || r_wdata !== 64'h0102_0304_0506_0708) begin
            tests_failed++; $display("FAIL sd_bus: got strb %h wdata %h want ff 0102030405060708", r_wstrb, r_wdata);
        end
    endtask

    task automatic test_errors();
        run_access(1'b1, 1'b0, 4'b0001, 2'b00, 64'h8000_0004, 64'h0, 64'h1);
        tests_run++;
        if (r_err !== 1'b1 || r_lat != 0 || r_req_seen !== 1'b0 || r_rdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL ld_misalign: got err %b lat %0d req %b data %h want 1 0 0 0", r_err, r_lat, r_req_seen, r_rdata);
        end
        run_access(1'b1, 1'b1, 4'b0100, 2'b00, 64'h8000_0001, 64'h1234, 64'h1);
        tests_run++;
        if (r_err !== 1'b1 || r_lat != 0 || r_req_seen !== 1'b0) begin
            tests_failed++; $display("FAIL sh_misalign: got err %b lat %0d req %b want 1 0 0", r_err, r_lat, r_req_seen);
        end
        run_access(1'b1, 1'b0, 4'b0011, 2'b00, 64'h8000_0000, 64'h0, 64'h1);
        tests_run++;
        if (r_err !== 1'b1 || r_req_seen !== 1'b0) begin
            tests_failed++; $display("FAIL bad_mask: got err %b req %b want 1 0", r_err, r_req_seen);
        end
        // Pass-through ignores the mask and offset entirely.
        run_access(1'b0, 1'b1, 4'b0011, 2'b00, 64'h8000_0007, 64'h55, 64'h1);
        tests_run++;
        if (r_err !== 1'b0 || r_rdata !== 64'h0 || r_lat != 0 || r_req_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL passthru: got err %b data %h lat %0d req %b want 0 0 0 0", r_err, r_rdata, r_lat, r_req_seen);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        in_valid = 1'b1; mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0010;
        sel_memdata = 2'b00; addr = 64'h8000_2004; wdata = 64'h0;
        @(posedge clk); #1;
        // Keep offering a different op; it must not be taken outside IDLE.
        addr = 64'h9000_0000; mem_wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b1;
            bus_rdata      = 64'hDEAD_DEAD_DEAD_DEAD;
            tests_run++;
            if (bus_req_valid !== 1'b1 || bus_addr !== 64'h8000_2000 || bus_wen !== 1'b0 ||
                bus_wstrb !== 8'h00 || in_ready !== 1'b0 || bus_resp_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_req_hold[%0d]: got v %b addr %h wen %b strb %h ir %b rr %b want 1 80002000 0 00 0 0",
                         i, bus_req_valid, bus_addr, bus_wen, bus_wstrb, in_ready, bus_resp_ready);
            end
            @(posedge clk); #1;
        end
        in_valid       = 1'b0;
        bus_resp_valid = 1'b0;
        bus_req_ready  = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        tests_run++;
        if (bus_resp_ready !== 1'b1 || bus_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_resp_state: got rr %b rv %b want 1 0", bus_resp_ready, bus_req_valid);
        end
        bus_resp_valid = 1'b1;
        bus_rdata      = 64'hF000_0001_1234_5678;
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
        out_ready      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_rdata !== 64'hFFFF_FFFF_F000_0001 || out_err !== 1'b0 ||
                in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_done_hold[%0d]: got ov %b data %h err %b ir %b want 1 fffffffff0000001 0 0",
                         i, out_valid, out_rdata, out_err, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_release: got ir %b ov %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_resp();
        @(negedge clk);
        in_valid = 1'b1; mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0001;
        sel_memdata = 2'b00; addr = 64'h8000_3000; wdata = 64'h0;
        @(posedge clk); #1;
        in_valid      = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        tests_run++;
        if (bus_resp_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_in_resp: got %b want 1", bus_resp_ready);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++; $display("FAIL rst_mid_async: got %h want 0", all_out);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_in_ready_early: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_in_ready_after: got %b want 1", in_ready);
        end
        run_access(1'b1, 1'b0, 4'b0001, 2'b00, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF);
        tests_run++;
        if (r_timeout !== 1'b0 || r_rdata !== 64'h0123_4567_89AB_CDEF || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ld: got %h err %b timeout %b want 0123456789abcdef 0 0", r_rdata, r_err, r_timeout);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; mem_ena = 1'b0; mem_wen = 1'b0; mem_mask = 4'b0000;
        sel_memdata = 2'b00; addr = 64'h0; wdata = 64'h0;
        out_ready = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = 64'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_back_pressure();
        test_reset_mid_resp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
